// File: rtl/triangle_project_ctrl_pkg.sv
// Shared half-precision vector types and the issue FSM encoding used by the
// triangle projection controller.
//   f16       : raw IEEE half-precision bit pattern
//   vec2_f16  : screen point, element 0 = x, 1 = y
//   vec3_f16  : 3-D vertex, element 0 = x, 1 = y, 2 = z
//   tri3_f16  : three 3-D vertices, index 0..2 (144 bits)
//   tri2_f16  : three screen points, index 0..2 (96 bits)
package triangle_project_ctrl_pkg;

  typedef logic [15:0]     f16;
  typedef f16      [1:0]   vec2_f16;
  typedef f16      [2:0]   vec3_f16;
  typedef vec3_f16 [2:0]   tri3_f16;
  typedef vec2_f16 [2:0]   tri2_f16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_ISSUE1,
    ST_ISSUE2
  } issue_state_t;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO holding assembled projected triangles.
//   clk, rst_n : clock, asynchronous active-low reset (empties FIFO, clears storage)
//   push, din  : write strobe and data (ignored when full)
//   pop        : read strobe (ignored when empty); push and pop may coincide
//   dout       : head entry, combinational
//   count      : current occupancy 0..DEPTH
module tri_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    wr_en    = push && (count_q != CNT_W'(DEPTH));
    rd_en    = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/triangle_project_ctrl.sv
// Feeds triangle vertices one per cycle into an external fixed-latency vertex
// projector, reassembles the returned screen points into triangles and queues
// them for downstream.
//   tri_valid/tri_ready/tri_in       : upstream triangle handshake (3-D vertices)
//   proj_in_valid/proj_vertex        : to projector input
//   proj_pt_valid/proj_pt            : from projector output (in order, no backpressure)
//   tri2d_valid/tri2d_ready/tri2d_out: projected triangle FIFO head
//   busy                             : issuing or vertices still in flight
//   err                              : sticky, projector result with nothing in flight
module triangle_project_ctrl
  import triangle_project_ctrl_pkg::*;
#(
  parameter int unsigned TRI_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    tri_valid,
  output logic    tri_ready,
  input  tri3_f16 tri_in,
  output logic    proj_in_valid,
  output vec3_f16 proj_vertex,
  input  logic    proj_pt_valid,
  input  vec2_f16 proj_pt,
  output logic    tri2d_valid,
  input  logic    tri2d_ready,
  output tri2_f16 tri2d_out,
  output logic    busy,
  output logic    err
);

  localparam int unsigned RESV_W = $clog2(TRI_DEPTH + 1);
  localparam int unsigned IFL_W  = $clog2(3 * TRI_DEPTH + 1);
  localparam int unsigned CNT_W  = $clog2(TRI_DEPTH + 1);

  issue_state_t      state_q, state_d;
  tri3_f16           tri_q, tri_d;
  logic [RESV_W-1:0] resv_q, resv_d;
  logic [IFL_W-1:0]  ifl_q, ifl_d;
  logic [1:0]        slot_q, slot_d;
  tri2_f16           asm_q, asm_d;
  logic              push_q, push_d;
  logic              err_q, err_d;

  logic              accept, pop, pt_ok;
  logic [CNT_W-1:0]  fifo_count;

  // Credit counts triangles from acceptance until popped, so the FIFO always
  // has room for every triangle already handed to the projector. Gated by
  // rst_n so no handshake is offered while reset is held.
  assign tri_ready = rst_n
                  && (state_q == ST_IDLE || state_q == ST_ISSUE2)
                  && (resv_q < RESV_W'(TRI_DEPTH));
  assign accept    = tri_valid && tri_ready;
  assign pop       = tri2d_valid && tri2d_ready;
  assign pt_ok     = proj_pt_valid && (ifl_q != '0);

  always_comb begin
    state_d       = state_q;
    tri_d         = tri_q;
    proj_in_valid = 1'b0;
    proj_vertex   = tri_q[2];
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE0;
      end
      ST_ISSUE0: begin
        proj_in_valid = 1'b1;
        proj_vertex   = tri_q[0];
        state_d       = ST_ISSUE1;
      end
      ST_ISSUE1: begin
        proj_in_valid = 1'b1;
        proj_vertex   = tri_q[1];
        state_d       = ST_ISSUE2;
      end
      ST_ISSUE2: begin
        proj_in_valid = 1'b1;
        proj_vertex   = tri_q[2];
        state_d       = accept ? ST_ISSUE0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) tri_d = tri_in;
  end

  always_comb begin
    resv_d = resv_q + RESV_W'(accept) - RESV_W'(pop);
    ifl_d  = ifl_q + IFL_W'(proj_in_valid) - IFL_W'(pt_ok);
    err_d  = err_q || (proj_pt_valid && (ifl_q == '0));
    asm_d  = asm_q;
    slot_d = slot_q;
    if (pt_ok) begin
      asm_d[slot_q] = proj_pt;
      slot_d        = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
    end
    // The FIFO takes asm_q one cycle after slot 2 lands; a vertex-0 result of
    // the next triangle in that same cycle only overwrites slot 0 at its end.
    push_d = pt_ok && (slot_q == 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tri_q   <= '0;
      resv_q  <= '0;
      ifl_q   <= '0;
      slot_q  <= '0;
      asm_q   <= '0;
      push_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      resv_q  <= resv_d;
      ifl_q   <= ifl_d;
      slot_q  <= slot_d;
      asm_q   <= asm_d;
      push_q  <= push_d;
      err_q   <= err_d;
    end
  end

  tri_fifo #(
    .WIDTH($bits(tri2_f16)),
    .DEPTH(TRI_DEPTH)
  ) u_tri_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (asm_q),
    .pop   (pop),
    .dout  (tri2d_out),
    .count (fifo_count)
  );

  assign tri2d_valid = (fifo_count != '0);
  assign busy        = (state_q != ST_IDLE) || (ifl_q != '0);
  assign err         = err_q;

endmodule

// File: tb/tb_triangle_project_ctrl.sv
// Directed bench for triangle_project_ctrl with a 7-cycle in-order projector
// model (near clip 1.0: screen = (x/-z, y/-z)).
module tb_triangle_project_ctrl;
  import triangle_project_ctrl_pkg::*;

  localparam int unsigned LAT = 7;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    tri_valid = 1'b0;
  logic    tri_ready;
  tri3_f16 tri_in = '0;
  logic    proj_in_valid;
  vec3_f16 proj_vertex;
  logic    proj_pt_valid;
  vec2_f16 proj_pt;
  logic    tri2d_valid;
  logic    tri2d_ready = 1'b0;
  tri2_f16 tri2d_out;
  logic    busy;
  logic    err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  triangle_project_ctrl #(.TRI_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .tri_in        (tri_in),
    .proj_in_valid (proj_in_valid),
    .proj_vertex   (proj_vertex),
    .proj_pt_valid (proj_pt_valid),
    .proj_pt       (proj_pt),
    .tri2d_valid   (tri2d_valid),
    .tri2d_ready   (tri2d_ready),
    .tri2d_out     (tri2d_out),
    .busy          (busy),
    .err           (err)
  );

  // Projection for the vertices this bench uses: z = -1 maps (x,y) through,
  // two further vertices are tabulated by hand.
  function automatic vec2_f16 proj_f(input vec3_f16 v);
    vec2_f16 r;
    r = '0;
    if (v[2] == 16'hBC00) begin
      r[0] = v[0];
      r[1] = v[1];
    end else if (v == {16'hC000, 16'h4000, 16'h3C00}) begin
      r[0] = 16'h3800;
      r[1] = 16'h3C00;
    end else if (v == {16'hC400, 16'h4400, 16'h4200}) begin
      r[0] = 16'h3A00;
      r[1] = 16'h3C00;
    end
    return r;
  endfunction

  function automatic tri3_f16 mk_tri(input int k);
    tri3_f16 t;
    for (int j = 0; j < 3; j++) begin
      t[j][0] = 16'(32'h1000 + k * 16 + j);
      t[j][1] = 16'(32'h2000 + k * 16 + j);
      t[j][2] = 16'hBC00;
    end
    return t;
  endfunction

  function automatic tri2_f16 exp_of(input tri3_f16 t);
    tri2_f16 r;
    for (int j = 0; j < 3; j++) r[j] = proj_f(t[j]);
    return r;
  endfunction

  // Projector model, reset from the same source as the DUT.
  logic [LAT-1:0] pv_q;
  vec2_f16        pp_q [LAT];
  logic           inj_valid = 1'b0;
  vec2_f16        inj_pt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < LAT; i++) pp_q[i] <= '0;
    end else begin
      pv_q    <= {pv_q[LAT-2:0], proj_in_valid};
      pp_q[0] <= proj_f(proj_vertex);
      for (int i = 1; i < LAT; i++) pp_q[i] <= pp_q[i-1];
    end
  end

  assign proj_pt_valid = pv_q[LAT-1] | inj_valid;
  assign proj_pt       = inj_valid ? inj_pt : pp_q[LAT-1];

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge.
  task automatic send_tri(input tri3_f16 t);
    int g;
    g = 0;
    tri_in    = t;
    tri_valid = 1'b1;
    while (!tri_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("send_timeout", 0, 1);
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("quiet_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_exp(input string tag, input tri2_f16 e);
    check({tag, "_valid"}, tri2d_valid, 1);
    check(tag, tri2d_out, e);
    tri2d_ready = 1'b1;
    @(negedge clk);
    tri2d_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tri3_f16 t1;
    tri2_f16 e1;
    tri2_f16 exq[$];
    int      issue_cnt;
    int      got;
    int      acc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tri_ready", tri_ready, 0);
    check("rst_proj_in_valid", proj_in_valid, 0);
    check("rst_tri2d_valid", tri2d_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_proj_vertex", proj_vertex, 0);
    check("rst_tri2d_out", tri2d_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", tri_ready, 1);

    // Single triangle: (1,2,-2) (3,4,-4) (0,0,-1)
    t1[0] = {16'hC000, 16'h4000, 16'h3C00};
    t1[1] = {16'hC400, 16'h4400, 16'h4200};
    t1[2] = {16'hBC00, 16'h0000, 16'h0000};
    e1[0] = {16'h3C00, 16'h3800};
    e1[1] = {16'h3C00, 16'h3A00};
    e1[2] = {16'h0000, 16'h0000};
    tri_in    = t1;
    tri_valid = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    check("single_iv1", proj_in_valid, 1);
    check("single_v0", proj_vertex, t1[0]);
    @(negedge clk);
    check("single_iv2", proj_in_valid, 1);
    check("single_v1", proj_vertex, t1[1]);
    @(negedge clk);
    check("single_iv3", proj_in_valid, 1);
    check("single_v2", proj_vertex, t1[2]);
    @(negedge clk);
    check("single_iv4", proj_in_valid, 0);
    check("single_hold", proj_vertex, t1[2]);
    check("single_busy", busy, 1);
    repeat (7) @(negedge clk);
    check("single_early", tri2d_valid, 0);
    @(negedge clk);
    pop_exp("single_out", e1);
    check("single_drained", tri2d_valid, 0);
    check("single_idle", busy, 0);
    check("single_err", err, 0);

    // Back-to-back: 8 triangles, tri_valid held, downstream always ready
    tri2d_ready = 1'b1;
    issue_cnt = 0;
    got = 0;
    acc = 0;
    for (int c = 0; c < 300 && got < 8; c++) begin
      if (proj_in_valid) issue_cnt++;
      if (tri2d_valid) begin
        if (exq.size() == 0) check("b2b_extra", 1, 0);
        else check("b2b_out", tri2d_out, exq.pop_front());
        got++;
      end
      if (acc < 8) begin
        tri_valid = 1'b1;
        tri_in    = mk_tri(acc);
        if (tri_ready) begin
          exq.push_back(exp_of(mk_tri(acc)));
          acc++;
        end
      end else begin
        tri_valid = 1'b0;
      end
      @(negedge clk);
    end
    tri_valid   = 1'b0;
    tri2d_ready = 1'b0;
    check("b2b_count", got, 8);
    check("b2b_issue_cycles", issue_cnt, 24);
    wait_quiet();

    // Backpressure: only TRI_DEPTH triangles accepted
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      tri_valid = 1'b1;
      tri_in    = mk_tri(16 + acc);
      if (tri_ready) begin
        exq.push_back(exp_of(mk_tri(16 + acc)));
        acc++;
      end
      @(negedge clk);
    end
    tri_valid = 1'b0;
    check("bp_accepts", acc, 4);
    check("bp_ready_low", tri_ready, 0);
    check("bp_same_cycle", tri_ready, 0);
    pop_exp("bp_out0", exq.pop_front());
    check("bp_credit", tri_ready, 1);
    for (int i = 1; i < 4; i++) pop_exp("bp_out", exq.pop_front());
    check("bp_drained", tri2d_valid, 0);

    // Unexpected projector result while idle
    check("unexp_pre_err", err, 0);
    inj_pt    = {16'h1234, 16'h5678};
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    check("unexp_err", err, 1);
    repeat (4) @(negedge clk);
    check("unexp_no_out", tri2d_valid, 0);
    send_tri(mk_tri(30));
    wait_quiet();
    pop_exp("unexp_next", exp_of(mk_tri(30)));
    check("unexp_sticky", err, 1);

    // Reset during ISSUE1
    tri_in    = mk_tri(40);
    tri_valid = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    @(negedge clk);
    check("mid_in_issue1", proj_vertex, mk_tri(40)[1]);
    rst_n = 1'b0;
    #1;
    check("mid_proj_in_valid", proj_in_valid, 0);
    check("mid_tri_ready", tri_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_err", err, 0);
    check("mid_proj_vertex", proj_vertex, 0);
    check("mid_tri2d_out", tri2d_out, 0);
    check("mid_tri2d_valid", tri2d_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("mid_no_stale", tri2d_valid, 0);
    send_tri(mk_tri(41));
    wait_quiet();
    pop_exp("mid_next", exp_of(mk_tri(41)));
    check("mid_single", tri2d_valid, 0);

    // Simultaneous accept and pop with three reserved
    for (int i = 0; i < 3; i++) begin
      send_tri(mk_tri(50 + i));
      exq.push_back(exp_of(mk_tri(50 + i)));
    end
    wait_quiet();
    tri_in      = mk_tri(53);
    tri_valid   = 1'b1;
    tri2d_ready = 1'b1;
    check("sim_ready_pre", tri_ready, 1);
    check("sim_pop_data", tri2d_out, exq.pop_front());
    exq.push_back(exp_of(mk_tri(53)));
    @(negedge clk);
    tri_valid   = 1'b0;
    tri2d_ready = 1'b0;
    wait_quiet();
    check("sim_resv3", tri_ready, 1);
    send_tri(mk_tri(54));
    exq.push_back(exp_of(mk_tri(54)));
    wait_quiet();
    check("sim_full", tri_ready, 0);
    for (int i = 0; i < 4; i++) pop_exp("sim_out", exq.pop_front());
    check("sim_drained", tri2d_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/triangle_project_ctrl.md
TRIANGLE_PROJECT_CTRL -- requirements
Module: triangle_project_ctrl

Interface
REQ-001 SHALL have parameter TRI_DEPTH, default 4: triangle result-FIFO depth and maximum reserved triangles; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port tri_valid, input, 1: upstream triangle valid.
REQ-005 SHALL have port tri_ready, output, 1: triangle accepted on cycles with tri_valid && tri_ready.
REQ-006 SHALL have port tri_in, input, tri3_f16 (144 bits): three vec3_f16 vertices, index 0..2.
REQ-007 SHALL have port proj_in_valid, output, 1: drives the vertex projector's input_valid.
REQ-008 SHALL have port proj_vertex, output, vec3_f16: drives the projector's vertex_3d.
REQ-009 SHALL have port proj_pt_valid, input, 1: projector screen_pt_valid.
REQ-010 SHALL have port proj_pt, input, vec2_f16: projector screen_pt.
REQ-011 SHALL have port tri2d_valid, output, 1: projected triangle available.
REQ-012 SHALL have port tri2d_ready, input, 1: downstream pop; a pop happens on tri2d_valid && tri2d_ready.
REQ-013 SHALL have port tri2d_out, output, tri2_f16 (96 bits): projected vertices, index 0..2, in input order.
REQ-014 SHALL have port busy, output, 1: high when the FSM is not IDLE or any vertex is in flight.
REQ-015 SHALL have port err, output, 1: sticky error, set on an unexpected projector result.

Function
REQ-016 SHALL implement issue FSM states IDLE, ISSUE0, ISSUE1, ISSUE2.
- Acceptance in IDLE or ISSUE2 goes to ISSUE0.
- ISSUE0 goes to ISSUE1, ISSUE1 goes to ISSUE2.
- ISSUE2 without acceptance goes to IDLE.
REQ-017 SHALL register tri_in on acceptance and drive proj_in_valid=1 with vertex 0, 1, 2 during ISSUE0, ISSUE1, ISSUE2 respectively.
- Triangle accepted at cycle T issues its vertices at T+1, T+2, T+3.
- Sustained throughput is one triangle per 3 cycles.
REQ-018 SHALL drive proj_in_valid=0 and proj_vertex held at its last value in IDLE.
REQ-019 SHALL keep a reservation counter resv (0..TRI_DEPTH).
- +1 on acceptance, -1 on pop; unchanged when both occur in the same cycle.
REQ-020 SHALL assert tri_ready = (state==IDLE || state==ISSUE2) && resv < TRI_DEPTH; a same-cycle pop does not open credit.
REQ-021 SHALL treat the projector as fixed-latency, in-order and lossless with no backpressure; the reservation scheme guarantees the FIFO never overflows.
REQ-022 SHALL keep an in-flight vertex counter.
- +1 per issued vertex, -1 per proj_pt_valid, net update when both occur in one cycle.
- Maximum is 3*TRI_DEPTH.
REQ-023 SHALL assemble results in a 3-slot register with a slot index 0..2.
- Each proj_pt_valid writes proj_pt into the current slot and advances the index, wrapping 2 to 0.
- When slot 2 is written, the completed triangle is pushed into the FIFO on the next cycle.
REQ-024 SHALL, on proj_pt_valid while the in-flight count is 0, set err, discard the result and leave the slot index unchanged.
REQ-025 SHALL present the FIFO head combinationally.
- tri2d_valid = FIFO not empty.
- A push into an empty FIFO at cycle C makes tri2d_valid high at C+1.
- Simultaneous push and pop are both honoured.
REQ-026 SHALL make latency from proj_pt_valid of vertex 2 to tri2d_valid equal to 2 cycles when the FIFO was empty.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set:
- FSM to IDLE, resv=0, in-flight=0, slot index=0, FIFO empty;
- tri_ready=0, proj_in_valid=0, tri2d_valid=0, busy=0, err=0;
- proj_vertex and tri2d_out to 0.
REQ-028 SHALL drop any triangle in flight when reset is asserted mid-operation; the projector must be reset from the same source (rst = ~rst_n) so stale results never reach this block.
REQ-029 SHALL clear err only by reset.

Structure
REQ-030 SHALL add typedefs tri3_f16 (array of 3 vec3_f16) and tri2_f16 (array of 3 vec2_f16) to the shared types package beside f16, vec2_f16 and vec3_f16.
REQ-031 SHALL instantiate one sub-module tri_fifo (synchronous FIFO, width and depth parameters, asynchronous active-low reset, count output).
REQ-032 SHALL not instantiate the projector; the integrator connects it at the next level up.

Verification
REQ-033 SHALL cover a single triangle.
- Stimulus: vertices (1,2,-2), (3,4,-4), (0,0,-1), projector model latency 7, near clip 1.0.
- Response: proj_in_valid at T+1..T+3; tri2d_out = (0.5,1.0), (0.75,1.0), (0,0), valid at the vertex-2 result plus 2 cycles.
REQ-034 SHALL cover back-to-back triangles: 8 triangles with tri_valid held high and tri2d_ready=1 give proj_in_valid continuously high for 24 cycles and outputs in order.
REQ-035 SHALL cover backpressure: with tri2d_ready=0, 4 triangles are accepted, tri_ready then stays 0; one pop gives tri_ready=1 on the next cycle and no FIFO overflow.
REQ-036 SHALL cover an unexpected result: a proj_pt_valid pulse while idle sets err=1, tri2d_valid stays 0, and the next triangle still assembles correctly.
REQ-037 SHALL cover reset mid-operation: rst_n pulsed low during ISSUE1 gives all outputs 0 immediately, and the next triangle completes normally.
REQ-038 SHALL cover simultaneous accept and pop at resv=3 (TRI_DEPTH=4): resv stays 3 and tri_ready stays 1.
